// File: rtl/aes_block_loader.sv
// aes_block_loader: byte-serial front end for the AES core.
// Bytes arrive over a valid/ready handshake and are assembled in a shadow
// buffer. Complete key frames (4*nk bytes) commit to Key. Complete message
// frames (16 bytes) commit to Message. If the output slot is still occupied
// when a frame completes, the loader holds it in PENDING until out_ready is
// seen high.
module aes_block_loader #(
    parameter int nk = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [0:127]      Message,
    output logic [0:32*nk-1]  Key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              key_loaded,
    output logic              err
);

    localparam int KW = 32 * nk;
    localparam int CW = $clog2(4 * nk);
    localparam logic [CW-1:0] MSG_LAST = CW'(15);
    localparam logic [CW-1:0] KEY_LAST = CW'(4 * nk - 1);

    typedef enum logic {
        FILL,
        PENDING
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            frame_key;
    logic [0:KW-1]   shadow;
    logic [0:KW-1]   shadow_next;
    logic            accept;
    logic            is_key;
    logic            last_byte;
    logic            slot_free;
    logic            consume;
    logic            do_commit;
    logic            commit_is_key;

    assign accept        = in_valid && in_ready && (state == FILL);
    assign is_key        = (count == '0) ? in_sel : frame_key;
    assign last_byte     = (count == (is_key ? KEY_LAST : MSG_LAST));
    assign slot_free     = !out_valid || out_ready;
    assign consume       = out_valid && out_ready;
    assign do_commit     = (accept && last_byte && slot_free) ||
                           ((state == PENDING) && out_ready);
    assign commit_is_key = (state == FILL) ? is_key : frame_key;

    // Shadow buffer with the byte being accepted this cycle already merged in,
    // so a frame can commit on the same edge that accepts its final byte.
    always_comb begin
        shadow_next = shadow;
        if (accept) begin
            shadow_next[{count, 3'b000} +: 8] = in_data;
        end
    end

    // Handshake FSM, byte counter, and commit of completed frames to the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            count      <= '0;
            frame_key  <= 1'b0;
            shadow     <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
            Message    <= '0;
            Key        <= '0;
        end else begin
            err    <= 1'b0;
            shadow <= shadow_next;
            if (consume) begin
                out_valid <= 1'b0;
            end
            if (do_commit) begin
                if (commit_is_key) begin
                    Key        <= shadow_next;
                    key_loaded <= 1'b1;
                    out_valid  <= 1'b0;
                end else if (key_loaded) begin
                    Message   <= shadow_next[0:127];
                    out_valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (count == '0) begin
                            frame_key <= in_sel;
                        end
                        if (last_byte) begin
                            count <= '0;
                            if (!slot_free) begin
                                state    <= PENDING;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (out_ready) begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed testbench for aes_block_loader with one nk=4 and one nk=8 instance.
module tb_aes_block_loader;

    logic           clk;
    logic           rst_n;

    logic [7:0]     in_data4;
    logic           in_sel4;
    logic           in_valid4;
    logic           in_ready4;
    logic [0:127]   message4;
    logic [0:127]   key4;
    logic           out_valid4;
    logic           out_ready4;
    logic           key_loaded4;
    logic           err4;

    logic [7:0]     in_data8;
    logic           in_sel8;
    logic           in_valid8;
    logic           in_ready8;
    logic [0:127]   message8;
    logic [0:255]   key8;
    logic           out_valid8;
    logic           out_ready8;
    logic           key_loaded8;
    logic           err8;

    int             checks;
    int             errors;
    logic [0:255]   k8;

    aes_block_loader #(.nk(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data4),
        .in_sel     (in_sel4),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .Message    (message4),
        .Key        (key4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .key_loaded (key_loaded4),
        .err        (err4)
    );

    aes_block_loader #(.nk(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data8),
        .in_sel     (in_sel8),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .Message    (message8),
        .Key        (key8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .key_loaded (key_loaded8),
        .err        (err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one byte to the selected instance and return at the negedge after
    // the edge that accepted it.
    task automatic applyStimulus(input bit use8, input logic [7:0] d, input logic sel);
        int waited;
        waited = 0;
        if (use8) begin
            in_valid8 = 1'b1; in_data8 = d; in_sel8 = sel;
            while (!in_ready8 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 50) checkOutput("in_ready8 timeout", 256'(in_ready8), 256'd1);
        end else begin
            in_valid4 = 1'b1; in_data4 = d; in_sel4 = sel;
            while (!in_ready4 && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 50) checkOutput("in_ready4 timeout", 256'(in_ready4), 256'd1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
    endtask

    task automatic sendFrame(input bit use8, input logic [7:0] base, input logic [7:0] step,
                             input int n, input logic sel);
        logic [7:0] b;
        b = base;
        for (int i = 0; i < n; i++) begin
            applyStimulus(use8, b, sel);
            b = b + step;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_data4 = '0; in_sel4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
        in_data8 = '0; in_sel8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        k8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        // Power-on reset and release
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 256'(in_ready4), 256'd0);
        checkOutput("reset key_loaded", 256'(key_loaded4), 256'd0);
        rst_n = 1'b1;
        checkOutput("in_ready before first edge", 256'(in_ready4), 256'd0);
        @(negedge clk);
        checkOutput("in_ready after first edge", 256'(in_ready4), 256'd1);

        // Message with no key loaded is discarded with an err pulse
        sendFrame(1'b0, 8'h30, 8'h01, 16, 1'b0);
        checkOutput("nokey err", 256'(err4), 256'd1);
        checkOutput("nokey out_valid", 256'(out_valid4), 256'd0);
        checkOutput("nokey Message", 256'(message4), 256'd0);
        @(negedge clk);
        checkOutput("nokey err one cycle", 256'(err4), 256'd0);

        // nk=4 key then message with out_ready high
        sendFrame(1'b0, 8'h00, 8'h01, 15, 1'b1);
        checkOutput("key_loaded before byte 16", 256'(key_loaded4), 256'd0);
        applyStimulus(1'b0, 8'h0f, 1'b0);
        checkOutput("key_loaded after byte 16", 256'(key_loaded4), 256'd1);
        checkOutput("key commit out_valid", 256'(out_valid4), 256'd0);
        sendFrame(1'b0, 8'h00, 8'h11, 16, 1'b0);
        checkOutput("msg out_valid", 256'(out_valid4), 256'd1);
        checkOutput("msg Message", 256'(message4), 256'(128'h00112233445566778899aabbccddeeff));
        checkOutput("msg Key", 256'(key4), 256'(128'h000102030405060708090a0b0c0d0e0f));
        @(negedge clk);
        checkOutput("msg out_valid one cycle", 256'(out_valid4), 256'd0);

        // Backpressure: A held, B stalls in PENDING
        out_ready4 = 1'b0;
        sendFrame(1'b0, 8'ha0, 8'h01, 16, 1'b0);
        checkOutput("A out_valid", 256'(out_valid4), 256'd1);
        checkOutput("A Message", 256'(message4), 256'(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf));
        sendFrame(1'b0, 8'hb0, 8'h01, 16, 1'b0);
        checkOutput("B pending in_ready", 256'(in_ready4), 256'd0);
        checkOutput("B pending Message still A", 256'(message4),
                    256'(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf));
        repeat (2) @(negedge clk);
        checkOutput("B pending holds in_ready", 256'(in_ready4), 256'd0);
        checkOutput("B pending out_valid", 256'(out_valid4), 256'd1);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        checkOutput("B Message", 256'(message4), 256'(128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf));
        checkOutput("B out_valid", 256'(out_valid4), 256'd1);
        checkOutput("B in_ready after commit", 256'(in_ready4), 256'd1);
        out_ready4 = 1'b1;
        @(negedge clk);
        checkOutput("B consumed", 256'(out_valid4), 256'd0);

        // Asynchronous reset mid-frame with a pair held
        out_ready4 = 1'b0;
        sendFrame(1'b0, 8'hc0, 8'h01, 16, 1'b0);
        sendFrame(1'b0, 8'h70, 8'h01, 7, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst in_ready", 256'(in_ready4), 256'd0);
        checkOutput("async rst out_valid", 256'(out_valid4), 256'd0);
        checkOutput("async rst key_loaded", 256'(key_loaded4), 256'd0);
        checkOutput("async rst err", 256'(err4), 256'd0);
        checkOutput("async rst Message", 256'(message4), 256'd0);
        checkOutput("async rst Key", 256'(key4), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("post rst in_ready low", 256'(in_ready4), 256'd0);
        @(negedge clk);
        checkOutput("post rst in_ready high", 256'(in_ready4), 256'd1);
        out_ready4 = 1'b1;
        sendFrame(1'b0, 8'h10, 8'h01, 16, 1'b1);
        checkOutput("fresh Key", 256'(key4), 256'(128'h101112131415161718191a1b1c1d1e1f));
        sendFrame(1'b0, 8'h40, 8'h01, 16, 1'b0);
        checkOutput("fresh Message", 256'(message4), 256'(128'h404142434445464748494a4b4c4d4e4f));
        checkOutput("fresh out_valid", 256'(out_valid4), 256'd1);

        // nk=8 key load
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, k8[i*8 +: 8], 1'b1);
        checkOutput("nk8 key_loaded before byte 32", 256'(key_loaded8), 256'd0);
        applyStimulus(1'b1, k8[248 +: 8], 1'b0);
        checkOutput("nk8 key_loaded after byte 32", 256'(key_loaded8), 256'd1);
        checkOutput("nk8 Key", 256'(key8), 256'(k8));

        // nk=8 key frame stalls while a message is held
        out_ready8 = 1'b0;
        sendFrame(1'b1, 8'h55, 8'h01, 16, 1'b0);
        checkOutput("nk8 Message", 256'(message8), 256'(128'h55565758595a5b5c5d5e5f6061626364));
        checkOutput("nk8 msg out_valid", 256'(out_valid8), 256'd1);
        sendFrame(1'b1, 8'he0, 8'h01, 32, 1'b1);
        checkOutput("nk8 key pending in_ready", 256'(in_ready8), 256'd0);
        checkOutput("nk8 Key unchanged while held", 256'(key8), 256'(k8));
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checkOutput("nk8 new Key", 256'(key8),
                    256'h_e0e1e2e3e4e5e6e7e8e9eaebecedeeeff0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        checkOutput("nk8 key commit out_valid", 256'(out_valid8), 256'd0);
        checkOutput("nk8 in_ready after commit", 256'(in_ready8), 256'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
